// File: rtl/hoop_catch_ctrl_if.sv
// Handshake/bus bundle between the hoop mover side (master) and the catch controller (slave).
interface hoop_catch_ctrl_if;
  logic               startOfFrame;
  logic               pause;
  logic signed [10:0] hoopTopLeftY;
  logic               drawingRequestHoop;
  logic               drawingRequestPlayer;
  logic signed [10:0] spawnX;
  logic               towerHoopCollision;
  logic               hoopHidden;
  logic [7:0]         hoopsCollected;

  modport master (
    output startOfFrame, pause, hoopTopLeftY, drawingRequestHoop, drawingRequestPlayer,
    input  spawnX, towerHoopCollision, hoopHidden, hoopsCollected
  );

  modport slave (
    input  startOfFrame, pause, hoopTopLeftY, drawingRequestHoop, drawingRequestPlayer,
    output spawnX, towerHoopCollision, hoopHidden, hoopsCollected
  );
endinterface

// File: rtl/hoop_catch_ctrl.sv
// Hoop catch controller: LFSR spawn position, catch pulse, hide-until-respawn, saturating score.
// All outputs registered; catch pulse one cycle after overlap, spawnX updates on the frame-strobe edge.
module hoop_catch_ctrl #(
  parameter int          SCREEN_H   = 480,
  parameter int          SPAWN_MIN  = 20,
  parameter int          SPAWN_SPAN = 400,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          COUNT_MAX  = 255
) (
  input  logic              clk,
  input  logic              reset,
  hoop_catch_ctrl_if.slave  bus
);
  localparam logic signed [10:0] C_SCREEN_H  = SCREEN_H[10:0];
  localparam logic signed [10:0] C_SPAWN_MIN = SPAWN_MIN[10:0];
  localparam logic [9:0]         C_SPAN      = SPAWN_SPAN[9:0];
  localparam logic [7:0]         C_COUNT_MAX = COUNT_MAX[7:0];

  typedef enum logic {ACTIVE, CAUGHT} state_t;

  state_t             r_state;
  logic [15:0]        r_lfsr;
  logic signed [10:0] r_spawn_x;
  logic               r_coll;
  logic               r_hidden;
  logic               r_caught_frame;
  logic [7:0]         r_count;

  logic [15:0] w_lfsr_nxt;
  logic [9:0]  w_raw;
  logic [9:0]  w_off;
  logic        w_offscreen;
  logic        w_spawn_upd;
  logic        w_catch;

  assign w_lfsr_nxt  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_raw       = {1'b0, w_lfsr_nxt[8:0]};
  assign w_off       = (w_raw >= C_SPAN) ? (w_raw - C_SPAN) : w_raw;
  // Signed compare so a hoop still above the screen (negative Y) is not taken as off-screen.
  assign w_offscreen = bus.hoopTopLeftY > C_SCREEN_H;
  assign w_spawn_upd = bus.startOfFrame && !bus.pause && !w_offscreen;
  assign w_catch     = bus.drawingRequestHoop && bus.drawingRequestPlayer &&
                       !bus.pause && !r_caught_frame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr    <= LFSR_SEED;
      r_spawn_x <= C_SPAWN_MIN;
    end else if (w_spawn_upd) begin
      r_lfsr    <= w_lfsr_nxt;
      r_spawn_x <= C_SPAWN_MIN + $signed({1'b0, w_off});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ACTIVE;
      r_coll         <= 1'b0;
      r_hidden       <= 1'b0;
      r_caught_frame <= 1'b0;
      r_count        <= 8'd0;
    end else begin
      r_coll <= 1'b0;
      if (bus.startOfFrame) begin
        r_caught_frame <= 1'b0;
      end
      case (r_state)
        ACTIVE: begin
          // A catch on the frame-strobe cycle wins over the per-frame clear above.
          if (w_catch) begin
            r_state        <= CAUGHT;
            r_coll         <= 1'b1;
            r_hidden       <= 1'b1;
            r_caught_frame <= 1'b1;
            if (r_count != C_COUNT_MAX) begin
              r_count <= r_count + 8'd1;
            end
          end
        end
        CAUGHT: begin
          if (bus.startOfFrame && w_offscreen) begin
            r_state  <= ACTIVE;
            r_hidden <= 1'b0;
          end
        end
        default: r_state <= ACTIVE;
      endcase
    end
  end

  assign bus.spawnX             = r_spawn_x;
  assign bus.towerHoopCollision = r_coll;
  assign bus.hoopHidden         = r_hidden;
  assign bus.hoopsCollected     = r_count;
endmodule

// File: tb/tb_hoop_catch_ctrl.sv
// Directed-vector bench for hoop_catch_ctrl: spawn stepping/hold, catch pulse, pause, saturation, async reset.
module tb_hoop_catch_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;

  hoop_catch_ctrl_if bus();

  hoop_catch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0]        m_lfsr;
  logic signed [10:0] m_spawn;
  int                 m_count;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic signed [10:0] spawn_of(input logic [15:0] s);
    int o;
    o = int'(s[8:0]);
    if (o >= 400) o = o - 400;
    return 11'(20 + o);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int y);
    bus.startOfFrame = 1'b1;
    bus.hoopTopLeftY = 11'(y);
    tick();
    bus.startOfFrame = 1'b0;
    if (!bus.pause && y <= 480) begin
      m_lfsr  = lfsr_step(m_lfsr);
      m_spawn = spawn_of(m_lfsr);
    end
  endtask

  task automatic test_reset();
    bus.startOfFrame = 0; bus.pause = 0; bus.hoopTopLeftY = 11'sd100;
    bus.drawingRequestHoop = 0; bus.drawingRequestPlayer = 0;
    #2 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    m_lfsr = 16'hACE1; m_spawn = 11'sd20; m_count = 0;
    n_vec++; if (bus.spawnX !== 11'sd20) begin n_err++; $display("FAIL reset_spawnX got %0d exp 20", bus.spawnX); end
    n_vec++; if (bus.towerHoopCollision !== 1'b0) begin n_err++; $display("FAIL reset_coll got %b exp 0", bus.towerHoopCollision); end
    n_vec++; if (bus.hoopHidden !== 1'b0) begin n_err++; $display("FAIL reset_hidden got %b exp 0", bus.hoopHidden); end
    n_vec++; if (bus.hoopsCollected !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", bus.hoopsCollected); end
  endtask

  task automatic test_spawn();
    frame(100);
    n_vec++; if (bus.spawnX !== 11'sd71) begin n_err++; $display("FAIL spawn_first got %0d exp 71", bus.spawnX); end
    frame(500);
    n_vec++; if (bus.spawnX !== 11'sd71) begin n_err++; $display("FAIL spawn_hold_offscreen got %0d exp 71", bus.spawnX); end
    frame(-58);
    n_vec++; if (bus.spawnX !== 11'sd411) begin n_err++; $display("FAIL spawn_negative_y got %0d exp 411", bus.spawnX); end
    frame(480);
    n_vec++; if (bus.spawnX !== 11'sd291) begin n_err++; $display("FAIL spawn_at_screen_h got %0d exp 291", bus.spawnX); end
    tick(); tick();
    n_vec++; if (bus.spawnX !== m_spawn) begin n_err++; $display("FAIL spawn_stable_in_frame got %0d exp %0d", bus.spawnX, m_spawn); end
  endtask

  task automatic test_catch();
    int pulses;
    logic first;
    pulses = 0;
    bus.drawingRequestHoop = 1; bus.drawingRequestPlayer = 1;
    tick();
    first = bus.towerHoopCollision;
    if (first) pulses++;
    for (int i = 1; i < 10; i++) begin
      tick();
      if (bus.towerHoopCollision) pulses++;
    end
    bus.drawingRequestHoop = 0; bus.drawingRequestPlayer = 0;
    m_count = 1;
    n_vec++; if (first !== 1'b1) begin n_err++; $display("FAIL catch_pulse_latency got %b exp 1", first); end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL catch_pulse_count got %0d exp 1", pulses); end
    n_vec++; if (bus.hoopsCollected !== 8'd1) begin n_err++; $display("FAIL catch_count got %0d exp 1", bus.hoopsCollected); end
    n_vec++; if (bus.hoopHidden !== 1'b1) begin n_err++; $display("FAIL catch_hidden got %b exp 1", bus.hoopHidden); end
    tick();
    bus.drawingRequestHoop = 1; bus.drawingRequestPlayer = 1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.towerHoopCollision) pulses++;
    end
    bus.drawingRequestHoop = 0; bus.drawingRequestPlayer = 0;
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL catch_second_same_frame got %0d exp 0", pulses); end
    frame(300);
    n_vec++; if (bus.hoopHidden !== 1'b1) begin n_err++; $display("FAIL caught_onscreen_hidden got %b exp 1", bus.hoopHidden); end
    n_vec++; if (bus.spawnX !== m_spawn) begin n_err++; $display("FAIL caught_spawn_step got %0d exp %0d", bus.spawnX, m_spawn); end
    frame(481);
    n_vec++; if (bus.hoopHidden !== 1'b0) begin n_err++; $display("FAIL respawn_unhide got %b exp 0", bus.hoopHidden); end
    n_vec++; if (bus.spawnX !== m_spawn) begin n_err++; $display("FAIL respawn_spawn_hold got %0d exp %0d", bus.spawnX, m_spawn); end
    bus.drawingRequestHoop = 1; bus.drawingRequestPlayer = 1;
    tick();
    bus.drawingRequestHoop = 0; bus.drawingRequestPlayer = 0;
    m_count = 2;
    n_vec++; if (bus.towerHoopCollision !== 1'b1) begin n_err++; $display("FAIL recatch_pulse got %b exp 1", bus.towerHoopCollision); end
    tick();
    n_vec++; if (bus.towerHoopCollision !== 1'b0) begin n_err++; $display("FAIL recatch_pulse_width got %b exp 0", bus.towerHoopCollision); end
    n_vec++; if (bus.hoopsCollected !== 8'd2) begin n_err++; $display("FAIL recatch_count got %0d exp 2", bus.hoopsCollected); end
  endtask

  task automatic test_simultaneous();
    frame(481);
    bus.drawingRequestHoop = 1; bus.drawingRequestPlayer = 1;
    frame(100);
    bus.drawingRequestHoop = 0; bus.drawingRequestPlayer = 0;
    m_count = 3;
    n_vec++; if (bus.towerHoopCollision !== 1'b1) begin n_err++; $display("FAIL simul_pulse got %b exp 1", bus.towerHoopCollision); end
    n_vec++; if (bus.hoopHidden !== 1'b1) begin n_err++; $display("FAIL simul_hidden got %b exp 1", bus.hoopHidden); end
    n_vec++; if (bus.spawnX !== m_spawn) begin n_err++; $display("FAIL simul_spawn got %0d exp %0d", bus.spawnX, m_spawn); end
    n_vec++; if (bus.hoopsCollected !== 8'd3) begin n_err++; $display("FAIL simul_count got %0d exp 3", bus.hoopsCollected); end
  endtask

  task automatic test_pause();
    int pulses;
    logic signed [10:0] frozen;
    frame(481);
    frozen = bus.spawnX;
    bus.pause = 1;
    bus.drawingRequestHoop = 1; bus.drawingRequestPlayer = 1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.towerHoopCollision) pulses++;
    end
    frame(100);
    if (bus.towerHoopCollision) pulses++;
    bus.drawingRequestHoop = 0; bus.drawingRequestPlayer = 0;
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL pause_no_pulse got %0d exp 0", pulses); end
    n_vec++; if (bus.spawnX !== frozen) begin n_err++; $display("FAIL pause_spawn_frozen got %0d exp %0d", bus.spawnX, frozen); end
    n_vec++; if (bus.hoopsCollected !== 8'(m_count)) begin n_err++; $display("FAIL pause_count got %0d exp %0d", bus.hoopsCollected, m_count); end
    bus.pause = 0;
    bus.drawingRequestHoop = 1; bus.drawingRequestPlayer = 1;
    tick();
    bus.drawingRequestHoop = 0; bus.drawingRequestPlayer = 0;
    m_count++;
    n_vec++; if (bus.towerHoopCollision !== 1'b1) begin n_err++; $display("FAIL unpause_pulse got %b exp 1", bus.towerHoopCollision); end
    bus.pause = 1;
    frame(300);
    n_vec++; if (bus.hoopHidden !== 1'b1) begin n_err++; $display("FAIL pause_caught_held got %b exp 1", bus.hoopHidden); end
    frame(481);
    n_vec++; if (bus.hoopHidden !== 1'b0) begin n_err++; $display("FAIL pause_exit_evaluated got %b exp 0", bus.hoopHidden); end
    bus.pause = 0;
    frame(100);
    n_vec++; if (bus.spawnX !== m_spawn) begin n_err++; $display("FAIL pause_resume_step got %0d exp %0d", bus.spawnX, m_spawn); end
  endtask

  task automatic test_saturate();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 260; i++) begin
      bus.drawingRequestHoop = 1; bus.drawingRequestPlayer = 1;
      tick();
      if (bus.towerHoopCollision) pulses++;
      bus.drawingRequestHoop = 0; bus.drawingRequestPlayer = 0;
      frame(481);
      if (m_count < 255) m_count++;
    end
    n_vec++; if (pulses != 260) begin n_err++; $display("FAIL sat_pulses got %0d exp 260", pulses); end
    n_vec++; if (bus.hoopsCollected !== 8'd255) begin n_err++; $display("FAIL sat_count got %0d exp 255", bus.hoopsCollected); end
  endtask

  task automatic test_async_reset();
    bus.drawingRequestHoop = 1; bus.drawingRequestPlayer = 1;
    tick();
    bus.drawingRequestHoop = 0; bus.drawingRequestPlayer = 0;
    n_vec++; if (bus.hoopHidden !== 1'b1) begin n_err++; $display("FAIL prereset_hidden got %b exp 1", bus.hoopHidden); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (bus.hoopHidden !== 1'b0) begin n_err++; $display("FAIL areset_hidden got %b exp 0", bus.hoopHidden); end
    n_vec++; if (bus.hoopsCollected !== 8'd0) begin n_err++; $display("FAIL areset_count got %0d exp 0", bus.hoopsCollected); end
    n_vec++; if (bus.spawnX !== 11'sd20) begin n_err++; $display("FAIL areset_spawnX got %0d exp 20", bus.spawnX); end
    n_vec++; if (bus.towerHoopCollision !== 1'b0) begin n_err++; $display("FAIL areset_coll got %b exp 0", bus.towerHoopCollision); end
    tick();
    reset = 1'b0;
    tick();
    frame(100);
    n_vec++; if (bus.spawnX !== 11'sd71) begin n_err++; $display("FAIL areset_lfsr_seed got %0d exp 71", bus.spawnX); end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_catch();
    test_simultaneous();
    test_pause();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
